// File: rtl/charge_entry_ctrl.sv
// Key-entry sequencer: turns debounced keypad events into an 11-digit phone number
// plus a recharge amount, then offers the pair to billing over valid/ready.
module charge_entry_ctrl #(
    parameter int PHONE_DIGITS = 11,
    parameter int AMT_DIGITS   = 3,
    parameter int AMT_W        = 10,
    parameter int MIN_AMT      = 10
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      startSet,
    input  logic [4:0]                num,
    input  logic                      start,
    input  logic                      clear,
    input  logic                      enter,
    input  logic                      req_ready,
    output logic                      req_valid,
    output logic [4*PHONE_DIGITS-1:0] phone_bcd,
    output logic [AMT_W-1:0]          amount,
    output logic [3:0]                phone_cnt,
    output logic [1:0]                amt_cnt,
    output logic [1:0]                state,
    output logic                      err
);
    typedef enum logic [1:0] {IDLE = 2'd0, PHONE = 2'd1, AMOUNT = 2'd2, REQ = 2'd3} state_t;

    localparam logic [3:0]       PD  = 4'(PHONE_DIGITS);
    localparam logic [1:0]       AD  = 2'(AMT_DIGITS);
    localparam logic [AMT_W-1:0] MIN = AMT_W'(MIN_AMT);

    state_t           st;
    logic             set_q, key_go, rise, is_digit;
    logic [AMT_W+3:0] amt_next;

    assign rise     = startSet & ~set_q;
    assign is_digit = (num <= 5'd9);
    assign amt_next = ({4'd0, amount} << 3) + ({4'd0, amount} << 1)
                    + {{AMT_W{1'b0}}, num[3:0]};
    assign state    = st;

    // key_go lags the strobe rise by a cycle so the scanner's decoded fields have settled.
    always_ff @(posedge CLK) begin
        if (RST) begin
            st        <= IDLE;
            set_q     <= 1'b0;
            key_go    <= 1'b0;
            req_valid <= 1'b0;
            phone_bcd <= '0;
            amount    <= '0;
            phone_cnt <= '0;
            amt_cnt   <= '0;
            err       <= 1'b0;
        end else begin
            set_q  <= startSet;
            key_go <= rise;
            err    <= 1'b0;
            if (req_valid && req_ready) begin
                req_valid <= 1'b0;
                st        <= IDLE;
            end else if (key_go) begin
                case (st)
                    IDLE: begin
                        if (start) begin
                            phone_bcd <= '0;
                            amount    <= '0;
                            phone_cnt <= '0;
                            amt_cnt   <= '0;
                            st        <= PHONE;
                        end
                    end
                    PHONE: begin
                        if (clear) begin
                            if (|phone_cnt) begin
                                phone_bcd <= '0;
                                phone_cnt <= '0;
                            end else begin
                                st <= IDLE;
                            end
                        end else if (start) begin
                            phone_bcd <= '0;
                            amount    <= '0;
                            phone_cnt <= '0;
                            amt_cnt   <= '0;
                        end else if (enter) begin
                            if (phone_cnt == PD) st <= AMOUNT;
                            else                 err <= 1'b1;
                        end else if (is_digit) begin
                            if (phone_cnt < PD) begin
                                phone_bcd <= {phone_bcd[4*PHONE_DIGITS-5:0], num[3:0]};
                                phone_cnt <= phone_cnt + 4'd1;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    AMOUNT: begin
                        if (clear) begin
                            if (|amt_cnt) begin
                                amount  <= '0;
                                amt_cnt <= '0;
                            end else begin
                                st <= PHONE;
                            end
                        end else if (start) begin
                            phone_bcd <= '0;
                            amount    <= '0;
                            phone_cnt <= '0;
                            amt_cnt   <= '0;
                            st        <= PHONE;
                        end else if (enter) begin
                            if (|amt_cnt && amount >= MIN) begin
                                st        <= REQ;
                                req_valid <= 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                        end else if (is_digit) begin
                            // A leading zero would waste one of the few amount digits.
                            if (amt_cnt == AD || (amt_cnt == 2'd0 && num[3:0] == 4'd0)) begin
                                err <= 1'b1;
                            end else begin
                                amount  <= amt_next[AMT_W-1:0];
                                amt_cnt <= amt_cnt + 2'd1;
                            end
                        end
                    end
                    REQ: begin
                        if (clear) begin
                            req_valid <= 1'b0;
                            st        <= IDLE;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end
endmodule
